// File: rtl/route_lookup.sv
// route_lookup
//   Longest-prefix-match router stage sitting behind the packet parser.
//   A parsed IPv4 destination is compared against a small software-written
//   route table, one entry per cycle. A hit forwards the payload stream on the
//   egress AXI-Stream with tdest set to the matched port and presents the
//   next-hop MAC. A miss drains and discards the payload. hdr_ready pulses
//   once the packet has been fully consumed.
//
// Ports
//   axis_clk, axis_reset      clock, synchronous active-high reset
//   cfg_*                     route table write port (one entry per strobe)
//   ip_dest_addr, hdr_valid   header from parser (hdr_valid is a 1-cycle pulse)
//   hdr_ready                 1-cycle pulse: packet finished
//   s_axis_*                  payload from parser
//   m_axis_*                  egress payload, m_axis_tdest = matched port
//   next_hop_mac              MAC of the matched route
//   fwd_count, drop_count     wrapping 32-bit packet counters
module route_lookup #(
    parameter int NUM_ROUTES = 8,
    parameter int PORT_WIDTH = 2,
    parameter int IDX_WIDTH  = $clog2(NUM_ROUTES)
) (
    input  logic                  axis_clk,
    input  logic                  axis_reset,
    input  logic                  cfg_wr_en,
    input  logic [IDX_WIDTH-1:0]  cfg_wr_idx,
    input  logic                  cfg_entry_valid,
    input  logic [31:0]           cfg_ip,
    input  logic [31:0]           cfg_mask,
    input  logic [PORT_WIDTH-1:0] cfg_port,
    input  logic [47:0]           cfg_mac,
    input  logic [31:0]           ip_dest_addr,
    input  logic                  hdr_valid,
    output logic                  hdr_ready,
    input  logic [31:0]           s_axis_tdata,
    input  logic [3:0]            s_axis_tkeep,
    input  logic                  s_axis_tvalid,
    input  logic                  s_axis_tlast,
    output logic                  s_axis_tready,
    output logic [31:0]           m_axis_tdata,
    output logic [3:0]            m_axis_tkeep,
    output logic                  m_axis_tvalid,
    output logic                  m_axis_tlast,
    output logic [PORT_WIDTH-1:0] m_axis_tdest,
    input  logic                  m_axis_tready,
    output logic [47:0]           next_hop_mac,
    output logic [31:0]           fwd_count,
    output logic [31:0]           drop_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_FORWARD,
        S_DROP,
        S_DONE
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    // Route table: only the valid bits are reset, the payload fields are
    // meaningless while their valid bit is clear.
    logic [NUM_ROUTES-1:0] r_tbl_valid;
    logic [31:0]           r_tbl_ip   [NUM_ROUTES];
    logic [31:0]           r_tbl_mask [NUM_ROUTES];
    logic [PORT_WIDTH-1:0] r_tbl_port [NUM_ROUTES];
    logic [47:0]           r_tbl_mac  [NUM_ROUTES];

    // Lookup working registers, (re)initialised on every accepted header.
    logic [31:0]           r_ip;
    logic [IDX_WIDTH-1:0]  r_idx;
    logic                  r_best_vld;
    logic [31:0]           r_best_mask;
    logic [PORT_WIDTH-1:0] r_best_port;
    logic [47:0]           r_best_mac;

    logic [PORT_WIDTH-1:0] r_tdest;
    logic [47:0]           r_mac;
    logic [31:0]           r_fwd_count;
    logic [31:0]           r_drop_count;

    logic                  w_cfg_idx_ok;
    logic                  w_ent_valid;
    logic [31:0]           w_ent_ip;
    logic [31:0]           w_ent_mask;
    logic                  w_ent_hit;
    logic                  w_take;
    logic                  w_last;
    logic                  w_fin_vld;
    logic [PORT_WIDTH-1:0] w_fin_port;
    logic [47:0]           w_fin_mac;
    logic                  w_s_tready;
    logic                  w_m_tvalid;
    logic                  w_fwd_done;
    logic                  w_drop_done;

    // Indices beyond the table (non power-of-two sizes) are ignored.
    assign w_cfg_idx_ok = (int'(cfg_wr_idx) < NUM_ROUTES);

    // Entry under scan this cycle; writes landing earlier are already visible.
    assign w_ent_valid = r_tbl_valid[r_idx];
    assign w_ent_ip    = r_tbl_ip[r_idx];
    assign w_ent_mask  = r_tbl_mask[r_idx];
    assign w_ent_hit   = w_ent_valid && ((r_ip & w_ent_mask) == (w_ent_ip & w_ent_mask));
    // Strictly greater: on equal masks the lower index already held wins.
    assign w_take      = w_ent_hit && (!r_best_vld || (w_ent_mask > r_best_mask));
    assign w_last      = (r_idx == IDX_WIDTH'(NUM_ROUTES - 1));

    // Final decision must include the entry scanned in the last cycle.
    assign w_fin_vld   = r_best_vld || w_take;
    assign w_fin_port  = w_take ? r_tbl_port[r_idx] : r_best_port;
    assign w_fin_mac   = w_take ? r_tbl_mac[r_idx]  : r_best_mac;

    assign w_fwd_done  = (r_state == S_FORWARD) && s_axis_tvalid && m_axis_tready && s_axis_tlast;
    assign w_drop_done = (r_state == S_DROP) && s_axis_tvalid && s_axis_tlast;

    always_ff @(posedge axis_clk) begin
        if (axis_reset) begin
            r_tbl_valid <= '0;
        end else if (cfg_wr_en && w_cfg_idx_ok) begin
            r_tbl_valid[cfg_wr_idx] <= cfg_entry_valid;
        end
    end

    always_ff @(posedge axis_clk) begin
        if (cfg_wr_en && w_cfg_idx_ok) begin
            r_tbl_ip[cfg_wr_idx]   <= cfg_ip;
            r_tbl_mask[cfg_wr_idx] <= cfg_mask;
            r_tbl_port[cfg_wr_idx] <= cfg_port;
            r_tbl_mac[cfg_wr_idx]  <= cfg_mac;
        end
    end

    always_ff @(posedge axis_clk) begin
        if (r_state == S_IDLE && hdr_valid) begin
            r_ip       <= ip_dest_addr;
            r_idx      <= '0;
            r_best_vld <= 1'b0;
        end else if (r_state == S_LOOKUP) begin
            r_idx <= r_idx + 1'b1;
            if (w_take) begin
                r_best_vld  <= 1'b1;
                r_best_mask <= w_ent_mask;
                r_best_port <= r_tbl_port[r_idx];
                r_best_mac  <= r_tbl_mac[r_idx];
            end
        end
    end

    always_ff @(posedge axis_clk) begin
        if (axis_reset) begin
            r_state      <= S_IDLE;
            r_tdest      <= '0;
            r_mac        <= '0;
            r_fwd_count  <= '0;
            r_drop_count <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == S_LOOKUP && w_last && w_fin_vld) begin
                r_tdest <= w_fin_port;
                r_mac   <= w_fin_mac;
            end
            if (w_fwd_done) begin
                r_fwd_count <= r_fwd_count + 32'd1;
            end
            if (w_drop_done) begin
                r_drop_count <= r_drop_count + 32'd1;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_s_tready  = 1'b0;
        w_m_tvalid  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (hdr_valid) begin
                    w_state_nxt = S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                if (w_last) begin
                    w_state_nxt = w_fin_vld ? S_FORWARD : S_DROP;
                end
            end
            S_FORWARD: begin
                w_s_tready = m_axis_tready;
                w_m_tvalid = s_axis_tvalid;
                if (w_fwd_done) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DROP: begin
                w_s_tready = 1'b1;
                if (w_drop_done) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Payload fields pass straight through; only tvalid is gated by state.
    assign m_axis_tdata  = s_axis_tdata;
    assign m_axis_tkeep  = s_axis_tkeep;
    assign m_axis_tlast  = s_axis_tlast;
    assign m_axis_tvalid = w_m_tvalid;
    assign s_axis_tready = w_s_tready;
    assign m_axis_tdest  = r_tdest;
    assign next_hop_mac  = r_mac;
    assign hdr_ready     = (r_state == S_DONE);
    assign fwd_count     = r_fwd_count;
    assign drop_count    = r_drop_count;

endmodule

// File: doc/route_lookup.md
Name: route_lookup

Overview:
- Sits directly downstream of the packet parser.
- Takes the parsed IPv4 destination address and the stripped payload stream, and runs a sequential longest-prefix-match over a small software-written route table.
- On a match, forwards the payload on an egress AXI-Stream with tdest set to the matched port, and presents the next-hop MAC.
- On a miss, drains and discards the payload.
- Returns hdr_ready to the parser once the packet is fully consumed.

Parameters:
- NUM_ROUTES, 8, number of route table entries (2..64).
- PORT_WIDTH, 2, width of egress port id / m_axis_tdest.
- IDX_WIDTH, clog2(NUM_ROUTES), table index width (derived).

Ports:
- axis_clk  in  1  single clock for all logic
- axis_reset  in  1  reset, synchronous, active-high
- cfg_wr_en  in  1  table write strobe
- cfg_wr_idx  in  IDX_WIDTH  entry index to write
- cfg_entry_valid  in  1  valid bit for written entry
- cfg_ip  in  32  route prefix
- cfg_mask  in  32  prefix mask (contiguous ones from MSB)
- cfg_port  in  PORT_WIDTH  egress port
- cfg_mac  in  48  next-hop MAC
- ip_dest_addr  in  32  parsed destination IP, sampled on hdr_valid
- hdr_valid  in  1  one-cycle header-valid pulse from parser
- hdr_ready  out  1  one-cycle pulse: packet finished
- s_axis_tdata/tkeep/tvalid/tlast  in  32/4/1/1  payload from parser
- s_axis_tready  out  1
- m_axis_tdata/tkeep/tvalid/tlast  out  32/4/1/1  egress payload
- m_axis_tdest  out  PORT_WIDTH  egress port
- m_axis_tready  in  1
- next_hop_mac  out  48  MAC of matched route, stable while in FORWARD
- fwd_count  out  32  forwarded packets
- drop_count  out  32  dropped packets

Behaviour:
- Reset (axis_reset=1 at a clock edge):
  - state=IDLE; all entry valid bits=0.
  - hdr_ready=0, s_axis_tready=0, m_axis_tvalid=0.
  - m_axis_tdest=0, next_hop_mac=0, fwd_count=drop_count=0.
  - Table ip/mask/port/mac contents need no reset.
  - Reset mid-packet abandons the packet with no counter update.
- Config:
  - cfg_wr_en writes all fields of entry cfg_wr_idx at the clock edge; the new value is visible from the next cycle.
  - Writes are accepted in every state.
  - An in-progress lookup uses each entry's value at the cycle that entry is scanned.
- States: IDLE, LOOKUP, FORWARD, DROP, DONE.
- IDLE:
  - On hdr_valid: latch ip_dest_addr, clear best-match register, idx=0, go to LOOKUP.
  - hdr_valid outside IDLE is ignored.
- LOOKUP:
  - Scans one entry per cycle, idx 0..NUM_ROUTES-1.
  - Entry i matches if valid && ((ip & mask_i) == (ip_i & mask_i)).
  - A match replaces the best match if none is held or mask_i > best_mask (unsigned). Ties keep the lower index.
  - mask=0 is a default route.
  - After the last entry (NUM_ROUTES cycles): a best match present loads m_axis_tdest and next_hop_mac and goes to FORWARD; otherwise goes to DROP.
  - Latency: hdr_valid at cycle T, FORWARD/DROP entered at T+NUM_ROUTES+1.
- s_axis_tready=0 in IDLE, LOOKUP and DONE; the payload waits upstream.
- FORWARD:
  - Combinational pass-through: m_axis_t{data,keep,last}=s_axis_*, m_axis_tvalid=s_axis_tvalid, s_axis_tready=m_axis_tready.
  - m_axis_tdest and next_hop_mac are held.
  - On a beat with s_axis_tvalid && s_axis_tready && s_axis_tlast: fwd_count+1, go to DONE.
- DROP:
  - s_axis_tready=1, m_axis_tvalid=0.
  - On a tlast beat: drop_count+1, go to DONE.
- DONE: hdr_ready=1 for exactly one cycle, then IDLE.
- Counters: 32-bit, wrap 0xFFFFFFFF to 0.
- Boundary conditions:
  - Single-beat packet (tvalid with tlast on the first beat) is handled.
  - m_axis_tready low holds FORWARD indefinitely with no data loss.
  - All entries invalid gives DROP.

Test Plan:
- Entry0 = {10.0.0.0, 255.0.0.0, port1, MAC 02:00:00:00:00:01}, valid. hdr ip 10.1.2.3, 3-beat payload 0x11111111/0x22222222/0x33333333 with last tkeep=0x3.
  -> m_axis carries the same beats and tkeep with tdest=1; next_hop_mac=0x020000000001; first beat no earlier than T+9; hdr_ready pulses 1 cycle; fwd_count=1.
- Add entry5 = {10.1.0.0, 255.255.0.0, port2}. Same ip 10.1.2.3.
  -> tdest=2 (longer prefix wins despite higher index).
- Entries 2 and 3 both {0.0.0.0, 0.0.0.0}, ports 3 and 0. ip 192.168.1.1.
  -> tdest=3 (tie keeps lower index).
- All entries invalid. ip 10.1.2.3, 4-beat payload.
  -> m_axis_tvalid stays 0; s_axis_tready=1 in DROP; drop_count=1; hdr_ready pulses.
- Forward with m_axis_tready toggling 1,0,0,1,... over a 5-beat payload.
  -> exactly 5 beats out, in order, none duplicated; s_axis_tready mirrors m_axis_tready.
- Assert axis_reset during FORWARD after 2 of 4 beats.
  -> next cycle: IDLE, s_axis_tready=0, counters 0, entry valid bits cleared; a subsequent packet is dropped.
